// File: rtl/carfield_periph_pkg.sv
// Shared types for the peripheral APB bridge: slave ids, address map rules and FSM states.
package carfield_periph_pkg;

    typedef enum logic [2:0] {
        CAN      = 3'd0,
        TIMER    = 3'd1,
        ADVTIMER = 3'd2,
        WDT      = 3'd3,
        HYP      = 3'd4
    } apb_slv_e;

    localparam int NumApbSlaves = 5;
    localparam logic [63:0] WindowSize = 64'h1000;

    typedef struct packed {
        apb_slv_e    idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } addr_rule_t;

    function automatic addr_rule_t make_rule(apb_slv_e slv, logic [63:0] base);
        return '{idx: slv, start_addr: base, end_addr: base + WindowSize};
    endfunction

    // Rule i describes slave i; end_addr is exclusive.
    localparam addr_rule_t ApbRules [NumApbSlaves] = '{
        make_rule(CAN,      64'h2000_1000),
        make_rule(TIMER,    64'h2000_4000),
        make_rule(ADVTIMER, 64'h2000_5000),
        make_rule(WDT,      64'h2000_7000),
        make_rule(HYP,      64'h2000_8000)
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

endpackage

// File: rtl/carfield_periph_addr_decode.sv
// Combinational address decoder: one-hot slave hit (masked by per-slave enable) plus miss flag.
module carfield_periph_addr_decode
    import carfield_periph_pkg::*;
#(
    parameter int AddrWidth = 48
) (
    input  logic [AddrWidth-1:0]    addr,
    input  addr_rule_t              rules [NumApbSlaves],
    input  logic [NumApbSlaves-1:0] en,
    output logic [NumApbSlaves-1:0] onehot,
    output logic                    miss
);

    logic [63:0]             addr_ext;
    logic [NumApbSlaves-1:0] rule_hit;

    // Full-width compare, so any nonzero bit above 31 falls outside every window.
    assign addr_ext = 64'(addr);

    for (genvar gi = 0; gi < NumApbSlaves; gi++) begin : g_rule
        assign rule_hit[gi] = (addr_ext >= rules[gi].start_addr) && (addr_ext < rules[gi].end_addr);
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NumApbSlaves; i++) begin
            if (rule_hit[i]) begin
                onehot[rules[i].idx] = en[rules[i].idx];
            end
        end
    end

    assign miss = ~|onehot;

endmodule

// File: rtl/carfield_periph_apb_bridge.sv
// Single-outstanding request/response to APB bridge for the peripheral subsystem.
// Optional ACCESS timeout enabled by defining CARFIELD_PERIPH_APB_TIMEOUT_EN.
module carfield_periph_apb_bridge
    import carfield_periph_pkg::*;
#(
    parameter int AddrWidth     = 48,
    parameter int DataWidth     = 32,
    parameter int CanEn         = 1,
    parameter int TimeoutCycles = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic                              req_write_i,
    input  logic [DataWidth-1:0]              req_wdata_i,
    input  logic [DataWidth/8-1:0]            req_strb_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [DataWidth-1:0]              rsp_rdata_o,
    output logic                              rsp_err_o,
    output logic [NumApbSlaves-1:0]           psel_o,
    output logic                              penable_o,
    output logic                              pwrite_o,
    output logic [31:0]                       paddr_o,
    output logic [DataWidth-1:0]              pwdata_o,
    output logic [DataWidth/8-1:0]            pstrb_o,
    input  logic [NumApbSlaves*DataWidth-1:0] prdata_i,
    input  logic [NumApbSlaves-1:0]           pready_i,
    input  logic [NumApbSlaves-1:0]           pslverr_i
);

    localparam int StrbWidth = DataWidth / 8;
    // CAN is slave index 0; disabling it turns its window into a miss.
    localparam logic [NumApbSlaves-1:0] SlaveEn =
        (CanEn != 0) ? {NumApbSlaves{1'b1}} : {{(NumApbSlaves-1){1'b1}}, 1'b0};

    apb_state_e              state_reg, state_next;
    logic [31:0]             addr_reg;
    logic                    write_reg;
    logic [DataWidth-1:0]    wdata_reg;
    logic [StrbWidth-1:0]    strb_reg;
    logic [NumApbSlaves-1:0] sel_reg;
    logic [DataWidth-1:0]    rdata_reg;
    logic                    err_reg;

    logic [NumApbSlaves-1:0] dec_onehot;
    logic                    dec_miss;
    logic                    accept, xfer_done, xfer_timeout;
    logic                    pready_sel, pslverr_sel;
    logic [DataWidth-1:0]    prdata_sel;
    logic [DataWidth-1:0]    prdata_masked [NumApbSlaves];

    carfield_periph_addr_decode #(
        .AddrWidth (AddrWidth)
    ) u_decode (
        .addr   (req_addr_i),
        .rules  (ApbRules),
        .en     (SlaveEn),
        .onehot (dec_onehot),
        .miss   (dec_miss)
    );

    // Only the registered selection is allowed to reach the response path.
    for (genvar gi = 0; gi < NumApbSlaves; gi++) begin : g_prdata
        assign prdata_masked[gi] = prdata_i[gi*DataWidth +: DataWidth] & {DataWidth{sel_reg[gi]}};
    end

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NumApbSlaves; i++) begin
            prdata_sel = prdata_sel | prdata_masked[i];
        end
    end

    assign pready_sel  = |(pready_i & sel_reg);
    assign pslverr_sel = |(pslverr_i & sel_reg);

`ifdef CARFIELD_PERIPH_APB_TIMEOUT_EN
    localparam int CntWidth = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
    logic [CntWidth-1:0] cnt_reg;

    // Once the limit is reached the abort wins even over a pready in the same cycle.
    assign xfer_timeout = (state_reg == ST_ACCESS) && (cnt_reg == CntWidth'(TimeoutCycles));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            cnt_reg <= '0;
        end else if ((state_reg == ST_ACCESS) && !pready_sel && !xfer_timeout) begin
            cnt_reg <= cnt_reg + CntWidth'(1);
        end
    end
`else
    assign xfer_timeout = 1'b0;
`endif

    assign accept    = (state_reg == ST_IDLE) && req_valid_i;
    assign xfer_done = (state_reg == ST_ACCESS) && pready_sel && !xfer_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        psel_o      = '0;
        penable_o   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (accept) begin
                    state_next = dec_miss ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_o     = sel_reg;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_o    = sel_reg;
                penable_o = 1'b1;
                if (xfer_done || xfer_timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            strb_reg  <= '0;
            sel_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg  <= 32'(req_addr_i);
                write_reg <= req_write_i;
                wdata_reg <= req_wdata_i;
                strb_reg  <= req_strb_i;
                sel_reg   <= dec_onehot;
                rdata_reg <= '0;
                err_reg   <= dec_miss;
            end
            if (xfer_done) begin
                err_reg   <= pslverr_sel;
                rdata_reg <= (write_reg || pslverr_sel) ? '0 : prdata_sel;
            end
            if (xfer_timeout) begin
                err_reg   <= 1'b1;
                rdata_reg <= '0;
            end
        end
    end

    assign paddr_o     = addr_reg;
    assign pwrite_o    = write_reg;
    assign pwdata_o    = wdata_reg;
    assign pstrb_o     = strb_reg;
    assign rsp_rdata_o = rdata_reg;
    assign rsp_err_o   = err_reg;

endmodule

// File: tb/tb_carfield_periph_apb_bridge.sv
// Scoreboard bench for carfield_periph_apb_bridge: random requests, APB slave model, response monitor.
module tb_carfield_periph_apb_bridge;

    localparam int AW = 48;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NS = 5;
`ifdef CARFIELD_PERIPH_APB_TIMEOUT_EN
    localparam int CAN_EN = 1;
    localparam int TO     = 4;
`else
    localparam int CAN_EN = 0;
    localparam int TO     = 1000000;
`endif

    logic             clk, rst_i;
    logic             req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0]    req_addr_i;
    logic [DW-1:0]    req_wdata_i;
    logic [SW-1:0]    req_strb_i;
    logic             rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [DW-1:0]    rsp_rdata_o;
    logic [NS-1:0]    psel_o, pready_i, pslverr_i;
    logic             penable_o, pwrite_o;
    logic [31:0]      paddr_o;
    logic [DW-1:0]    pwdata_o;
    logic [SW-1:0]    pstrb_o;
    logic [NS*DW-1:0] prdata_i;

    carfield_periph_apb_bridge #(
        .AddrWidth(AW), .DataWidth(DW), .CanEn(CAN_EN), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i),
        .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [AW-1:0] addr; bit write; logic [DW-1:0] wdata; logic [SW-1:0] strb;
        int waits; bit slv_err; logic [DW-1:0] slv_rdata; int hold;
    } txn_t;
    typedef struct {
        int sel; logic [31:0] paddr; bit write; logic [DW-1:0] wdata; logic [SW-1:0] strb;
        int waits; bit err; logic [DW-1:0] rdata;
    } apb_exp_t;
    typedef struct {
        logic [DW-1:0] rdata; bit err; int latency; int hold; int accept_cycle;
    } rsp_exp_t;

    txn_t     plan_q[$];
    apb_exp_t apb_q[$];
    rsp_exp_t rsp_q[$];
    int tests = 0;
    int fails = 0;

    localparam logic [AW-1:0] BASES [NS] = '{48'h2000_1000, 48'h2000_4000, 48'h2000_5000,
                                             48'h2000_7000, 48'h2000_8000};

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference decode: the window list with the CAN enable applied.
    function automatic int exp_slave(logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= BASES[i] && a < BASES[i] + 48'h1000) return (i == 0 && CAN_EN == 0) ? -1 : i;
        end
        return -1;
    endfunction

    task automatic add(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input int waits, input bit err,
                       input logic [DW-1:0] rd, input int hold);
        txn_t t;
        t.addr = addr; t.write = wr; t.wdata = wd; t.strb = st;
        t.waits = waits; t.slv_err = err; t.slv_rdata = rd; t.hold = hold;
        plan_q.push_back(t);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check({tag, "_rsp_err"}, rsp_err_o, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
        check({tag, "_psel"}, psel_o, 0);
        check({tag, "_penable"}, penable_o, 0);
        check({tag, "_pwrite"}, pwrite_o, 0);
        check({tag, "_paddr"}, paddr_o, 0);
        check({tag, "_pwdata"}, pwdata_o, 0);
        check({tag, "_pstrb"}, pstrb_o, 0);
    endtask

    // Called at a negedge; returns at a later negedge once the request has been taken.
    task automatic issue(input txn_t t, input bit expect_rsp);
        int n, s;
        bit to;
        apb_exp_t a;
        rsp_exp_t r;
        req_valid_i = 1'b1; req_addr_i = t.addr; req_write_i = t.write;
        req_wdata_i = t.wdata; req_strb_i = t.strb;
        n = 0;
        while (!req_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", req_ready_o, 1);
        if (req_ready_o) begin
            s  = exp_slave(t.addr);
            to = (s >= 0) && (t.waits >= TO);
            if (s >= 0) begin
                a.sel = s; a.paddr = t.addr[31:0]; a.write = t.write; a.wdata = t.wdata;
                a.strb = t.strb; a.waits = t.waits; a.err = t.slv_err; a.rdata = t.slv_rdata;
                apb_q.push_back(a);
            end
            r.err          = (s < 0) || to || t.slv_err;
            r.rdata        = (s < 0 || to || t.write || t.slv_err) ? '0 : t.slv_rdata;
            r.latency      = (s < 0) ? 1 : 3 + (to ? TO : t.waits);
            r.hold         = t.hold;
            r.accept_cycle = cycle;
            if (expect_rsp) rsp_q.push_back(r);
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = {16'hFFFF, 32'($urandom)};
    endtask

    // APB slave model: checks SETUP/ACCESS outputs, answers after the planned wait states,
    // and drives random noise on every non-answering input.
    initial begin : apb_slave
        apb_exp_t cur;
        bit active;
        int acc;
        active = 0; acc = 0;
        pready_i = '0; pslverr_i = '0; prdata_i = '0;
        forever begin
            @(negedge clk);
            pready_i  = NS'($urandom);
            pslverr_i = NS'($urandom);
            for (int i = 0; i < NS; i++) prdata_i[i*DW +: DW] = $urandom;
            if (rst_i || psel_o == '0) begin
                active = 0;
                if (!rst_i) check("penable_without_psel", penable_o, 0);
            end else if (!penable_o) begin
                if (apb_q.size() == 0) begin
                    check("unexpected_psel", psel_o, 0);
                    active = 0;
                end else begin
                    cur = apb_q.pop_front();
                    active = 1; acc = 0;
                    check("setup_psel", psel_o, 1 << cur.sel);
                    check("setup_paddr", paddr_o, cur.paddr);
                    check("setup_pwrite", pwrite_o, cur.write);
                    check("setup_pwdata", pwdata_o, cur.wdata);
                    check("setup_pstrb", pstrb_o, cur.strb);
                end
            end else if (!active) begin
                check("access_without_setup", penable_o, 0);
            end else begin
                check("access_psel_hold", psel_o, 1 << cur.sel);
                check("access_paddr_hold", paddr_o, cur.paddr);
                if (acc == cur.waits) begin
                    pready_i[cur.sel]  = 1'b1;
                    pslverr_i[cur.sel] = cur.err;
                    prdata_i[cur.sel*DW +: DW] = cur.rdata;
                end else begin
                    pready_i[cur.sel] = 1'b0;
                end
                acc++;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, stalls rsp_ready as planned.
    initial begin : rsp_monitor
        rsp_exp_t cur;
        bit in_rsp;
        int hold;
        in_rsp = 0; hold = 0;
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                rsp_ready_i = 1'b0;
                in_rsp = 0;
                continue;
            end
            if (!rsp_valid_o) begin
                rsp_ready_i = 1'($urandom_range(0, 1));
                continue;
            end
            if (!in_rsp) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid_o, 0);
                    rsp_ready_i = 1'b1;
                    continue;
                end
                cur = rsp_q.pop_front();
                in_rsp = 1;
                hold = cur.hold;
                check("rsp_latency", cycle - cur.accept_cycle, cur.latency);
            end
            check("rsp_rdata", rsp_rdata_o, cur.rdata);
            check("rsp_err", rsp_err_o, cur.err);
            check("req_ready_in_resp", req_ready_o, 0);
            if (hold == 0) begin
                rsp_ready_i = 1'b1;
                in_rsp = 0;
            end else begin
                rsp_ready_i = 1'b0;
                hold--;
            end
        end
    end

    initial begin : driver
        txn_t t;
        int n, kind, w, gap;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
        req_wdata_i = '0; req_strb_i = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_i = 1'b0;

        add(48'h2000_4008, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h5555_AAAA, 0);
        add(48'h2000_7004, 0, 32'h0, 4'h0, 4, 0, 32'h0000_1234, 0);
        add(48'h2000_2000, 0, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 0);
        add(48'h2000_1000, 0, 32'h0, 4'h0, 0, 0, 32'h2222_2222, 0);
        add(48'h2000_8010, 0, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D, 3);
        add(48'h1_2000_4000, 0, 32'h0, 4'h0, 0, 0, 32'h3333_3333, 0);
        add(48'h2000_4FFC, 0, 32'h0, 4'h0, 2, 0, 32'h0BAD_0001, 1);
        add(48'h2000_5000, 1, 32'h0102_0304, 4'h3, 1, 0, 32'h4444_4444, 0);
        add(48'h2000_8FFC, 0, 32'h0, 4'h0, 0, 0, 32'h0BAD_0002, 0);
        add(48'h2000_9000, 0, 32'h0, 4'h0, 0, 0, 32'h6666_6666, 2);
        add(48'h2000_0FFC, 1, 32'h7777_7777, 4'hF, 0, 0, 32'h0, 0);
`ifdef CARFIELD_PERIPH_APB_TIMEOUT_EN
        add(48'h2000_1004, 0, 32'h0, 4'h0, 1000, 0, 32'h0000_0077, 0);
        add(48'h2000_1008, 0, 32'h0, 4'h0, 4, 0, 32'h0000_0088, 0);
`endif
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 3);
            w    = $urandom_range(0, NS - 1);
            case (kind)
                0: t.addr = BASES[w] + AW'($urandom_range(0, 1023) * 4);
                1: t.addr = 48'h2000_0000 + AW'($urandom_range(0, 16'h27FF) * 4);
                2: case ($urandom_range(0, 3))
                       0: t.addr = BASES[w] - 48'd4;
                       1: t.addr = BASES[w];
                       2: t.addr = BASES[w] + 48'hFFC;
                       default: t.addr = BASES[w] + 48'h1000;
                   endcase
                default: t.addr = BASES[w] | (AW'($urandom_range(1, 65535)) << 32);
            endcase
            t.write = 1'($urandom_range(0, 1));
            t.wdata = $urandom;
            t.strb = SW'($urandom);
            t.waits = $urandom_range(0, 6);
            t.slv_err = ($urandom_range(0, 3) == 0);
            t.slv_rdata = $urandom;
            t.hold = $urandom_range(0, 3);
            plan_q.push_back(t);
        end

        foreach (plan_q[i]) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            issue(plan_q[i], 1'b1);
        end

        n = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_rsp_q", rsp_q.size(), 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a long ACCESS: no response may follow.
        add(48'h2000_7010, 0, 32'h0, 4'h0, 60, 0, 32'h9999_9999, 0);
        issue(plan_q[plan_q.size()-1], 1'b0);
        n = 0;
        while (!penable_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_access", penable_o, 1);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst_i = 1'b0;
        apb_q.delete();
        repeat (10) @(negedge clk);
        check("idle_after_reset", req_ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
